// File: rtl/gpu_console_writer_pkg.sv
// gpu_console_writer_pkg: GPU memory map, console geometry, cell packing and writer FSM states
package gpu_console_writer_pkg;
  localparam logic [7:0] GPU_SELECT = 8'h02;
  localparam logic [10:0] CTRL_ADDR = 11'd0;
  localparam logic [10:0] STATUS_ADDR = 11'd1;
  localparam logic [10:0] CHAR_BASE = 11'd4;
  localparam int COLS = 40;
  localparam int ROWS = 30;
  localparam int CTRL_COPY = 0;
  localparam int CTRL_BLANK = 1;
  localparam logic [63:0] BLANK_WORD = 64'h20;
  typedef enum logic [3:0] {
    IDLE, WRITE_CHAR, FF_WR, FF_POLL, SCROLL_RD, SCROLL_WR, CLEAR_ROW, FLUSH_WR, FLUSH_POLL
  } writerState_t;
  function automatic logic [63:0] packCell(input logic [11:0] colour, input logic [7:0] code);
    return {44'b0, colour, code};
  endfunction
  function automatic logic [63:0] gpuAddress(input logic [10:0] offset);
    return {GPU_SELECT, 45'b0, offset};
  endfunction
endpackage

// File: rtl/gpu_cell_addr.sv
// gpu_cell_addr: maps a cursor position or a linear cell index to a GPU bus address
module gpu_cell_addr
  import gpu_console_writer_pkg::*;
(
  input  logic [4:0]  row,
  input  logic [5:0]  col,
  input  logic [10:0] linear,
  input  logic        useLinear,
  output logic [63:0] address
);
  logic [10:0] index;
  assign index = useLinear ? linear : 11'(row) * 11'(COLS) + 11'(col);
  assign address = gpuAddress(CHAR_BASE + index);
endmodule

// File: rtl/gpu_console_writer.sv
// gpu_console_writer: turns a character stream into GPU text framebuffer writes, with cursor, scroll and flush
module gpu_console_writer
  import gpu_console_writer_pkg::*;
(
  input  logic        clock,
  input  logic        resetN,
  input  logic        charValid,
  output logic        charReady,
  input  logic [7:0]  charCode,
  input  logic [11:0] charColour,
  input  logic        flush,
  output logic        busy,
  output logic [4:0]  cursorRow,
  output logic [5:0]  cursorCol,
  output logic [63:0] address,
  output logic [63:0] dataOut,
  output logic        dataOutEn,
  input  logic [63:0] dataIn,
  output logic        read,
  output logic        write
);
  writerState_t state, stateNext;
  logic [4:0]  rowNext;
  logic [5:0]  colNext;
  logic [10:0] idx, idxNext, linear;
  logic [7:0]  codeReg;
  logic [11:0] colourReg;
  logic [63:0] scrollWord, wordOut, cellAddress;
  logic        flushPending, ctrlSel, useLinear, accept, printable, lastRow;

  assign charReady = (state == IDLE) & ~flushPending;
  assign busy = state != IDLE;
  assign accept = charValid & charReady;
  assign printable = (charCode >= 8'h20) && (charCode <= 8'h7E);
  assign lastRow = cursorRow == 5'(ROWS - 1);
  assign dataOut = wordOut;
  assign dataOutEn = write;
  assign address = (read | write) ? (ctrlSel ? gpuAddress(CTRL_ADDR) : cellAddress) : 64'h0;

  gpu_cell_addr cellAddr (
    .row(cursorRow),
    .col(cursorCol),
    .linear(linear),
    .useLinear(useLinear),
    .address(cellAddress)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      cursorRow <= '0;
      cursorCol <= '0;
      idx <= '0;
      codeReg <= '0;
      colourReg <= '0;
      scrollWord <= '0;
      flushPending <= 1'b0;
    end else begin
      state <= stateNext;
      cursorRow <= rowNext;
      cursorCol <= colNext;
      idx <= idxNext;
      flushPending <= (state == IDLE && flushPending) ? 1'b0 : flushPending | flush;
      if (accept) begin
        codeReg <= charCode;
        colourReg <= charColour;
      end
      if (state == SCROLL_RD) scrollWord <= dataIn;
    end
  end

  // scroll index i runs COLS..COLS*ROWS-1 for the copy, then on through the last row for the clear,
  // so both write phases target CHAR_BASE + i - COLS
  always_comb begin
    stateNext = state;
    rowNext = cursorRow;
    colNext = cursorCol;
    idxNext = idx;
    read = 1'b0;
    write = 1'b0;
    ctrlSel = 1'b0;
    useLinear = 1'b0;
    wordOut = 64'h0;
    linear = (state == SCROLL_RD) ? idx : idx - 11'(COLS);
    case (state)
      IDLE: begin
        if (flushPending) stateNext = FLUSH_WR;
        else if (charValid) begin
          if (printable) stateNext = WRITE_CHAR;
          else if (charCode == 8'h0A) begin
            colNext = '0;
            if (lastRow) begin
              stateNext = SCROLL_RD;
              idxNext = 11'(COLS);
            end else rowNext = cursorRow + 5'd1;
          end
          else if (charCode == 8'h0D) colNext = '0;
          else if (charCode == 8'h08) colNext = (cursorCol == 6'd0) ? 6'd0 : cursorCol - 6'd1;
          else if (charCode == 8'h0C) stateNext = FF_WR;
        end
      end
      WRITE_CHAR: begin
        write = 1'b1;
        wordOut = packCell(colourReg, codeReg);
        stateNext = IDLE;
        if (cursorCol == 6'(COLS - 1)) begin
          colNext = '0;
          if (lastRow) begin
            stateNext = SCROLL_RD;
            idxNext = 11'(COLS);
          end else rowNext = cursorRow + 5'd1;
        end else colNext = cursorCol + 6'd1;
      end
      FF_WR: begin
        write = 1'b1;
        ctrlSel = 1'b1;
        wordOut = 64'h1 << CTRL_BLANK;
        rowNext = '0;
        colNext = '0;
        stateNext = FF_POLL;
      end
      FLUSH_WR: begin
        write = 1'b1;
        ctrlSel = 1'b1;
        wordOut = 64'h1 << CTRL_COPY;
        stateNext = FLUSH_POLL;
      end
      FF_POLL, FLUSH_POLL: begin
        read = 1'b1;
        ctrlSel = 1'b1;
        stateNext = (dataIn[1:0] == 2'b00) ? IDLE : state;
      end
      SCROLL_RD: begin
        read = 1'b1;
        useLinear = 1'b1;
        stateNext = SCROLL_WR;
      end
      SCROLL_WR: begin
        write = 1'b1;
        useLinear = 1'b1;
        wordOut = scrollWord;
        idxNext = idx + 11'd1;
        stateNext = (idx == 11'(COLS * ROWS - 1)) ? CLEAR_ROW : SCROLL_RD;
      end
      CLEAR_ROW: begin
        write = 1'b1;
        useLinear = 1'b1;
        wordOut = BLANK_WORD;
        idxNext = idx + 11'd1;
        stateNext = (idx == 11'(COLS * ROWS + COLS - 1)) ? IDLE : CLEAR_ROW;
      end
      default: stateNext = IDLE;
    endcase
  end
endmodule

// File: tb/tb_gpu_console_writer.sv
// tb_gpu_console_writer: directed checks of gpu_console_writer against a small GPU memory model
module tb_gpu_console_writer;
  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        charValid = 1'b0;
  logic        charReady;
  logic [7:0]  charCode = 8'h0;
  logic [11:0] charColour = 12'h0;
  logic        flush = 1'b0;
  logic        busy;
  logic [4:0]  cursorRow;
  logic [5:0]  cursorCol;
  logic [63:0] address, dataOut, dataIn;
  logic        dataOutEn, read, write;

  logic [63:0] mem [0:2047];
  logic [63:0] old [0:2047];
  logic [63:0] ctrlWord = 64'h0;
  logic [63:0] lastCtrl = 64'h0;
  logic [63:0] lastWrAddr = 64'h0;
  logic [63:0] lastWrData = 64'h0;
  int ctrlTimer = 0;
  int wrCount = 0;
  int badAddr = 0;
  int bothHigh = 0;
  logic doFill = 1'b0;
  int tests = 0;
  int failed = 0;
  int polls, badPoll, zeroCount, lowBad, badCells, n;
  logic prevZero;

  always #5 clock = ~clock;

  gpu_console_writer dut (
    .clock(clock), .resetN(resetN), .charValid(charValid), .charReady(charReady),
    .charCode(charCode), .charColour(charColour), .flush(flush), .busy(busy),
    .cursorRow(cursorRow), .cursorCol(cursorCol), .address(address), .dataOut(dataOut),
    .dataOutEn(dataOutEn), .dataIn(dataIn), .read(read), .write(write)
  );

  assign dataIn = !read ? 64'h0 : (address[10:0] == 11'd0 ? ctrlWord : mem[address[10:0]]);

  always @(posedge clock) begin
    if (doFill) for (int i = 0; i < 2048; i++) mem[i] <= 64'hC0DE_0000_0000_0000 | 64'(i);
    if (write) begin
      if (address[10:0] == 11'd0) begin
        ctrlWord <= dataOut;
        lastCtrl <= dataOut;
        ctrlTimer <= 0;
      end else mem[address[10:0]] <= dataOut;
      wrCount <= wrCount + 1;
      lastWrAddr <= address;
      lastWrData <= dataOut;
    end else if (ctrlWord != 64'h0) begin
      if (ctrlTimer == 499) ctrlWord <= 64'h0;
      else ctrlTimer <= ctrlTimer + 1;
    end
    if ((read | write) && address[63:11] != {8'h02, 45'b0}) badAddr <= badAddr + 1;
    if (read & write) bothHigh <= bothHigh + 1;
  end

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sendChar(input logic [7:0] c, input logic [11:0] colour);
    int k = 0;
    @(negedge clock);
    while (!charReady && k < 10000) begin
      @(negedge clock);
      k++;
    end
    charCode = c;
    charColour = colour;
    charValid = 1'b1;
    @(negedge clock);
    charValid = 1'b0;
  endtask

  task automatic checkCursor(input string tag, input int r, input int c);
    checkEq({tag, "_row"}, 64'(cursorRow), 64'(r));
    checkEq({tag, "_col"}, 64'(cursorCol), 64'(c));
  endtask

  task automatic pollWait(input string tag);
    int k = 0;
    while (!busy && k < 10) begin
      @(negedge clock);
      k++;
    end
    polls = 0;
    badPoll = 0;
    zeroCount = 0;
    prevZero = 1'b0;
    k = 0;
    while (busy && k < 5000) begin
      if (read) begin
        polls++;
        if (address[10:0] != 11'd0) badPoll++;
      end
      prevZero = read && dataIn[1:0] == 2'b00;
      if (prevZero) zeroCount++;
      @(negedge clock);
      k++;
    end
    checkEq({tag, "_idle"}, 64'(busy), 64'h0);
    checkEq({tag, "_polls"}, 64'(polls), 64'd501);
    checkEq({tag, "_pollAddr"}, 64'(badPoll), 64'h0);
    checkEq({tag, "_dropAfterZero"}, 64'(prevZero), 64'h1);
    checkEq({tag, "_zeroSeen"}, 64'(zeroCount), 64'h1);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 64'h0;
    repeat (2) @(negedge clock);
    checkEq("rst_busy", 64'(busy), 64'h0);
    checkEq("rst_ready", 64'(charReady), 64'h1);
    checkEq("rst_rw", 64'({read, write, dataOutEn}), 64'h0);
    checkEq("rst_addr", address, 64'h0);
    checkEq("rst_data", dataOut, 64'h0);
    checkCursor("rst", 0, 0);
    resetN = 1'b1;

    sendChar(8'h41, 12'hF00);
    checkEq("A_write", 64'({write, dataOutEn, read}), 64'h6);
    checkEq("A_addr", address, {8'h02, 45'b0, 11'd4});
    checkEq("A_data", dataOut, 64'hF0041);
    @(negedge clock);
    checkCursor("A", 0, 1);
    checkEq("A_ready", 64'(charReady), 64'h1);
    checkEq("A_writeDrop", 64'(write), 64'h0);

    for (int i = 1; i < 40; i++) sendChar(8'h30 + 8'(i % 10), 12'h123);
    @(negedge clock);
    checkCursor("wrap", 1, 0);
    checkEq("wrap_count", 64'(wrCount), 64'd40);
    checkEq("wrap_lastAddr", lastWrAddr, {8'h02, 45'b0, 11'd43});
    sendChar(8'h0D, 12'h0);
    checkCursor("cr", 1, 0);
    sendChar(8'h0A, 12'h0);
    checkCursor("lf", 2, 0);
    sendChar(8'h08, 12'h0);
    checkCursor("bsZero", 2, 0);
    sendChar(8'h78, 12'h0AB);
    @(negedge clock);
    checkCursor("x", 2, 1);
    checkEq("x_addr", lastWrAddr, {8'h02, 45'b0, 11'd84});
    checkEq("x_data", lastWrData, 64'h0AB78);
    sendChar(8'h08, 12'h0);
    checkCursor("bs", 2, 0);
    sendChar(8'h01, 12'h0);
    @(negedge clock);
    checkCursor("ignored", 2, 0);
    checkEq("ignored_noWrite", 64'(wrCount), 64'd41);
    checkEq("ignored_ready", 64'(charReady), 64'h1);

    for (int i = 0; i < 27; i++) sendChar(8'h0A, 12'h0);
    checkCursor("row29", 29, 0);
    @(negedge clock);
    doFill = 1'b1;
    @(negedge clock);
    doFill = 1'b0;
    for (int i = 0; i < 2048; i++) old[i] = mem[i];
    sendChar(8'h0A, 12'h0);
    n = 0;
    lowBad = 0;
    while (busy && n < 5000) begin
      if (charReady) lowBad++;
      n++;
      @(negedge clock);
    end
    checkEq("scroll_busyCycles", 64'(n), 64'd2360);
    checkEq("scroll_readyLow", 64'(lowBad), 64'h0);
    badCells = 0;
    for (int i = 0; i < 1160; i++) if (mem[4 + i] !== old[44 + i]) badCells++;
    checkEq("scroll_rowsMoved", 64'(badCells), 64'h0);
    checkEq("scroll_row28", mem[4 + 28 * 40 + 7], 64'hC0DE_0000_0000_0000 | 64'(4 + 29 * 40 + 7));
    badCells = 0;
    for (int i = 1164; i < 1204; i++) if (mem[i] !== 64'h20) badCells++;
    checkEq("scroll_lastBlank", 64'(badCells), 64'h0);
    checkEq("scroll_beyond", mem[1204], old[1204]);
    checkCursor("scroll", 29, 0);

    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    checkEq("flush_readyLow", 64'(charReady), 64'h0);
    pollWait("flush");
    checkEq("flush_ctrl", lastCtrl, 64'h1);
    checkEq("flush_ready", 64'(charReady), 64'h1);

    sendChar(8'h7A, 12'h0);
    @(negedge clock);
    checkCursor("z", 29, 1);
    sendChar(8'h0C, 12'h0);
    pollWait("ff");
    checkEq("ff_ctrl", lastCtrl, 64'h2);
    checkCursor("ff", 0, 0);

    for (int i = 0; i < 29; i++) sendChar(8'h0A, 12'h0);
    checkCursor("row29b", 29, 0);
    sendChar(8'h0A, 12'h0);
    repeat (100) @(negedge clock);
    checkEq("mid_active", 64'(read | write), 64'h1);
    #2 resetN = 1'b0;
    #1;
    checkEq("async_rw", 64'({read, write, dataOutEn}), 64'h0);
    checkEq("async_busy", 64'(busy), 64'h0);
    checkEq("async_addr", address, 64'h0);
    checkCursor("async", 0, 0);
    @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    checkEq("post_ready", 64'(charReady), 64'h1);
    checkEq("post_busy", 64'(busy), 64'h0);
    sendChar(8'h42, 12'h00F);
    @(negedge clock);
    checkEq("post_addr", lastWrAddr, {8'h02, 45'b0, 11'd4});
    checkEq("post_data", lastWrData, 64'h00F42);
    checkCursor("post", 0, 1);

    checkEq("never_both", 64'(bothHigh), 64'h0);
    checkEq("addr_select", 64'(badAddr), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
